joy_serializer: RTL and testbench

- Board-side emitter for the Neptuno DB9 joystick serial link: the transmitting end that the host-side joystick decoder reads over JOY_CLK / JOY_LOAD / JOY_DATA.
- Behaves as two cascaded parallel-in/serial-out shift registers, with input synchronisation, per-button debouncing and link-activity monitoring.
- Used as the adapter-CPLD implementation and as the bench responder for decoder verification.

---
 rtl/joy_serializer.sv | 198 +++++++++++++++++++
 tb/tb_joy_serializer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/joy_serializer.sv
// ---------------------------------------------------------------------------
// joy_serializer
//
// Board-side emitter for the Neptuno DB9 joystick serial link. Behaves like
// two cascaded parallel-in/serial-out shift registers: while the host holds
// JOY_LOAD low the frame is continuously reloaded from debounced buttons, and
// each JOY_CLK rising edge afterwards shifts the frame out MSB first.
//
// Ports:
//   clk_i          system clock, all logic synchronous to it
//   reset_i        asynchronous active-high reset
//   joy_clk_i      host shift clock (asynchronous)
//   joy_load_n_i   host parallel load, active-low (asynchronous)
//   joy_data_o     registered serial data to host
//   joy1_n_i       port-1 raw buttons, active-low {fire2,fire1,right,left,down,up}
//   joy2_n_i       port-2 raw buttons, same layout
//   link_active_o  high while load pulses arrive at least every IDLE_CYCLES
//   frame_count_o  completed load pulses, wraps at 255
//
// Frame (MSB first, active-low):
//   [15:10] joy1 {up,down,left,right,fire1,fire2}, [9:8] 1,
//   [7:2]   joy2 {up,down,left,right,fire1,fire2}, [1:0] 1
// ---------------------------------------------------------------------------
module joy_serializer #(
    parameter int unsigned DEBOUNCE_CYCLES = 500,
    parameter int unsigned IDLE_CYCLES     = 5000000,
    parameter int unsigned FRAME_BITS      = 16
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       joy_clk_i,
    input  logic       joy_load_n_i,
    output logic       joy_data_o,
    input  logic [5:0] joy1_n_i,
    input  logic [5:0] joy2_n_i,
    output logic       link_active_o,
    output logic [7:0] frame_count_o
);

    localparam int unsigned NumBtn  = 12;
    localparam int unsigned CntW    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned IdleW   = $clog2(IDLE_CYCLES + 1);
    localparam int unsigned BitCntW = $clog2(FRAME_BITS);

    localparam logic [CntW-1:0]    DbMax   = CntW'(DEBOUNCE_CYCLES - 1);
    localparam logic [IdleW-1:0]   IdleMax = IdleW'(IDLE_CYCLES);
    localparam logic [BitCntW-1:0] BitLast = BitCntW'(FRAME_BITS - 1);

    typedef enum logic [1:0] {StLoad, StShift, StDone} state_e;

    // ------------------------------------------------------------------
    // Synchronisers and edge detectors for the host link
    // ------------------------------------------------------------------
    logic jclk_s1_q, jclk_s2_q, jclk_s3_q;
    logic load_s1_q, load_s2_q, load_s3_q;
    logic clk_rise, load_rise;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            jclk_s1_q <= 1'b1;
            jclk_s2_q <= 1'b1;
            jclk_s3_q <= 1'b1;
            load_s1_q <= 1'b1;
            load_s2_q <= 1'b1;
            load_s3_q <= 1'b1;
        end else begin
            jclk_s1_q <= joy_clk_i;
            jclk_s2_q <= jclk_s1_q;
            jclk_s3_q <= jclk_s2_q;
            load_s1_q <= joy_load_n_i;
            load_s2_q <= load_s1_q;
            load_s3_q <= load_s2_q;
        end
    end

    assign clk_rise  = jclk_s2_q & ~jclk_s3_q;
    assign load_rise = load_s2_q & ~load_s3_q;

    // ------------------------------------------------------------------
    // Button synchronisers and per-bit debouncers
    // Bits [5:0] are port 1, [11:6] are port 2.
    // ------------------------------------------------------------------
    logic [NumBtn-1:0]           btn_s1_q, btn_s2_q;
    logic [NumBtn-1:0]           db_state_q, db_state_d;
    logic [NumBtn-1:0][CntW-1:0] db_cnt_q, db_cnt_d;

    always_comb begin
        for (int i = 0; i < NumBtn; i++) begin
            db_cnt_d[i]   = '0;
            db_state_d[i] = db_state_q[i];
            if (btn_s2_q[i] != db_state_q[i]) begin
                if (db_cnt_q[i] == DbMax) begin
                    db_state_d[i] = btn_s2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            btn_s1_q   <= '1;
            btn_s2_q   <= '1;
            db_state_q <= '1;
            db_cnt_q   <= '0;
        end else begin
            btn_s1_q   <= {joy2_n_i, joy1_n_i};
            btn_s2_q   <= btn_s1_q;
            db_state_q <= db_state_d;
            db_cnt_q   <= db_cnt_d;
        end
    end

    logic [15:0] frame;
    assign frame = {db_state_q[0], db_state_q[1], db_state_q[2],
                    db_state_q[3], db_state_q[4], db_state_q[5], 2'b11,
                    db_state_q[6], db_state_q[7], db_state_q[8],
                    db_state_q[9], db_state_q[10], db_state_q[11], 2'b11};

    // ------------------------------------------------------------------
    // Shift FSM, frame counter and idle monitor
    // ------------------------------------------------------------------
    state_e             state_q;
    logic [15:0]        shreg_q;
    logic [BitCntW-1:0] bit_cnt_q;
    logic               joy_data_q;
    logic [7:0]         frame_cnt_q;
    logic [IdleW-1:0]   idle_cnt_q;
    logic               link_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= StDone;
            shreg_q     <= '1;
            bit_cnt_q   <= '0;
            joy_data_q  <= 1'b1;
            frame_cnt_q <= '0;
            idle_cnt_q  <= '0;
            link_q      <= 1'b0;
        end else begin
            if (load_rise) begin
                idle_cnt_q <= '0;
                link_q     <= 1'b1;
            end else if (idle_cnt_q != IdleMax) begin
                idle_cnt_q <= idle_cnt_q + 1'b1;
                if (idle_cnt_q == IdleMax - 1'b1) begin
                    link_q <= 1'b0;
                end
            end

            if (!load_s2_q) begin
                // Transparent load: a coincident clock edge is ignored.
                state_q    <= StLoad;
                shreg_q    <= frame;
                joy_data_q <= frame[15];
                bit_cnt_q  <= '0;
            end else begin
                unique case (state_q)
                    StLoad: begin
                        if (load_rise) begin
                            state_q     <= StShift;
                            frame_cnt_q <= frame_cnt_q + 8'd1;
                        end
                        bit_cnt_q  <= '0;
                        joy_data_q <= shreg_q[15];
                    end
                    StShift: begin
                        if (clk_rise) begin
                            shreg_q   <= {shreg_q[14:0], 1'b1};
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                            if (bit_cnt_q == BitLast) begin
                                state_q <= StDone;
                            end
                        end
                        // Lags the shift by one cycle so the host sees a registered bit.
                        joy_data_q <= shreg_q[15];
                    end
                    StDone: begin
                        if (clk_rise) begin
                            shreg_q <= {shreg_q[14:0], 1'b1};
                        end
                        joy_data_q <= 1'b1;
                    end
                    default: begin
                        state_q    <= StDone;
                        joy_data_q <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign joy_data_o    = joy_data_q;
    assign link_active_o = link_q;
    assign frame_count_o = frame_cnt_q;

endmodule

// File: tb/tb_joy_serializer.sv
// ---------------------------------------------------------------------------
// tb_joy_serializer
//
// Self-checking bench for joy_serializer. Expected frames come from a
// behavioural model that maps button vectors straight to frame bit positions;
// frame count and link activity are tracked from the stimulus the bench drives.
// ---------------------------------------------------------------------------
module tb_joy_serializer;

    localparam int unsigned Db   = 20;
    localparam int unsigned Idle = 100;

    logic       clk = 1'b0;
    logic       reset;
    logic       joy_clk;
    logic       joy_load_n;
    logic       joy_data;
    logic [5:0] joy1_n;
    logic [5:0] joy2_n;
    logic       link_active;
    logic [7:0] frame_count;

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] exp_fc = 8'd0;

    always #5 clk = ~clk;

    joy_serializer #(
        .DEBOUNCE_CYCLES(Db),
        .IDLE_CYCLES    (Idle),
        .FRAME_BITS     (16)
    ) u_dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .joy_clk_i    (joy_clk),
        .joy_load_n_i (joy_load_n),
        .joy_data_o   (joy_data),
        .joy1_n_i     (joy1_n),
        .joy2_n_i     (joy2_n),
        .link_active_o(link_active),
        .frame_count_o(frame_count)
    );

    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    // Reference frame: button b of a port lands at (port MSB - b).
    function automatic logic [15:0] model_frame(input logic [5:0] j1, input logic [5:0] j2);
        logic [15:0] f;
        f = 16'hFFFF;
        for (int b = 0; b < 6; b++) begin
            f[15 - b] = j1[b];
            f[7 - b]  = j2[b];
        end
        return f;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic settle();
        tick(2 * Db + 5);
    endtask

    task automatic load_pulse(input string tag);
        joy_load_n = 1'b0;
        tick(8);
        joy_load_n = 1'b1;
        exp_fc     = exp_fc + 8'd1;
        tick(8);
        check_eq({tag, "_fc"}, {8'h00, frame_count}, {8'h00, exp_fc});
        check_eq({tag, "_link"}, {15'd0, link_active}, 16'd1);
    endtask

    // Sample then clock, like a host reading a '165 chain.
    task automatic read_bits(input int n, output logic [15:0] v);
        v = 16'hFFFF;
        for (int i = 0; i < n; i++) begin
            v[15 - i] = joy_data;
            joy_clk   = 1'b1;
            tick(20);
            joy_clk   = 1'b0;
            tick(20);
        end
    endtask

    logic [15:0] got;
    logic [15:0] exp_f;

    initial begin
        reset      = 1'b1;
        joy_clk    = 1'b0;
        joy_load_n = 1'b1;
        joy1_n     = 6'h3F;
        joy2_n     = 6'h3F;
        tick(3);
        check_eq("rst_data", {15'd0, joy_data}, 16'd1);
        check_eq("rst_fc", {8'h00, frame_count}, 16'd0);
        check_eq("rst_link", {15'd0, link_active}, 16'd0);
        reset = 1'b0;
        tick(3);
        check_eq("post_rst_data", {15'd0, joy_data}, 16'd1);

        // Basic frame: joy1 up, joy2 fire2.
        joy1_n = 6'b111110;
        joy2_n = 6'b011111;
        settle();
        load_pulse("basic");
        read_bits(16, got);
        check_eq("basic_frame", got, 16'h7FFB);
        check_eq("basic_model", got, model_frame(joy1_n, joy2_n));

        // Clocks past the end of the frame shift out ones only.
        read_bits(16, got);
        check_eq("done_ones", got, 16'hFFFF);
        check_eq("done_fc", {8'h00, frame_count}, {8'h00, exp_fc});

        // Glitch on joy1 fire1 shorter than the debounce window.
        joy1_n[4] = 1'b0;
        tick(Db - 2);
        joy1_n[4] = 1'b1;
        tick(5);
        load_pulse("glitch");
        read_bits(16, got);
        check_eq("glitch_bit11", {15'd0, got[11]}, 16'd1);
        check_eq("glitch_frame", got, model_frame(joy1_n, joy2_n));

        // Same button held long enough to be accepted.
        joy1_n[4] = 1'b0;
        tick(Db + 3);
        load_pulse("held");
        read_bits(16, got);
        check_eq("held_bit11", {15'd0, got[11]}, 16'd0);
        check_eq("held_frame", got, model_frame(joy1_n, joy2_n));

        // Abort mid-frame with a clock edge coincident with load.
        joy1_n = 6'b101010;
        joy2_n = 6'b010101;
        settle();
        exp_f = model_frame(joy1_n, joy2_n);
        load_pulse("abort_a");
        read_bits(5, got);
        check_eq("abort_part", got[15:11], exp_f[15:11]);
        joy_load_n = 1'b0;
        joy_clk    = 1'b1;
        tick(8);
        check_eq("abort_reload", {15'd0, joy_data}, {15'd0, exp_f[15]});
        joy_clk = 1'b0;
        tick(4);
        joy_load_n = 1'b1;
        exp_fc     = exp_fc + 8'd1;
        tick(8);
        check_eq("abort_fc", {8'h00, frame_count}, {8'h00, exp_fc});
        read_bits(16, got);
        check_eq("abort_frame", got, exp_f);

        // Randomised button patterns.
        for (int k = 0; k < 6; k++) begin
            joy1_n = 6'($urandom);
            joy2_n = 6'($urandom);
            settle();
            load_pulse("rand");
            read_bits(16, got);
            check_eq("rand_frame", got, model_frame(joy1_n, joy2_n));
        end

        // Idle monitor: three cycles of sync latency after the pin release.
        joy_load_n = 1'b0;
        tick(8);
        joy_load_n = 1'b1;
        exp_fc     = exp_fc + 8'd1;
        tick(Idle);
        check_eq("idle_still_up", {15'd0, link_active}, 16'd1);
        tick(6);
        check_eq("idle_down", {15'd0, link_active}, 16'd0);
        check_eq("idle_fc", {8'h00, frame_count}, {8'h00, exp_fc});
        load_pulse("idle_back");

        // Asynchronous reset mid-frame.
        joy1_n = 6'b110011;
        joy2_n = 6'b001100;
        settle();
        load_pulse("rst_mid");
        read_bits(7, got);
        reset = 1'b1;
        #2;
        check_eq("amid_data", {15'd0, joy_data}, 16'd1);
        check_eq("amid_fc", {8'h00, frame_count}, 16'd0);
        check_eq("amid_link", {15'd0, link_active}, 16'd0);
        tick(2);
        reset  = 1'b0;
        exp_fc = 8'd0;
        tick(3);
        check_eq("amid_idle_data", {15'd0, joy_data}, 16'd1);
        settle();
        load_pulse("after_rst");
        read_bits(16, got);
        check_eq("after_rst_frame", got, model_frame(joy1_n, joy2_n));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
